// File: rtl/agu_tile_stream_if.sv
// Output beat stream of the tile AGU.
//   master (AGU)     : drives out_valid/out_addr/out_null/out_id/out_last, samples out_ready
//   slave (consumer) : samples the beat, drives out_ready
// Lane l of out_addr occupies bits [l*ADDR_WIDTH +: ADDR_WIDTH].
interface agu_tile_stream_if #(
  parameter int LANES      = 4,
  parameter int ADDR_WIDTH = 32
);
  logic                             out_valid;
  logic                             out_ready;
  logic [LANES-1:0][ADDR_WIDTH-1:0] out_addr;
  logic [LANES-1:0]                 out_null;
  logic [1:0]                       out_id;
  logic                             out_last;

  modport master (output out_valid, out_addr, out_null, out_id, out_last, input out_ready);
  modport slave  (input out_valid, out_addr, out_null, out_id, out_last, output out_ready);
endinterface

// File: rtl/agu_tile_stream.sv
// Lane-parallel GEMM tile address generator. Walks an M x K x N tiled matmul
// (i, j, k order, k innermost) and streams LANES addresses per beat for the
// A, B and C tiles through a small output FIFO.
//   clk, rst            : clock, async active-high reset
//   cfg_valid_i/ready_o : config handshake (dims, tile sizes, bases, elem shift)
//   tile_req_i          : start the next tile (only looked at in WAIT_TILE)
//   tile_done_o         : pulse when the tile's last beat pops
//   all_tiles_done_o    : level, high in DONE
//   busy_o              : high outside IDLE/DONE
//   out_if              : beat stream (master side)

// One address lane: null when the lane falls past the effective tile width.
module agu_tile_lane #(
  parameter int              AW        = 32,
  parameter int              IW        = 16,
  parameter int              LANE      = 0,
  parameter logic [AW-1:0]   NULL_ADDR = '1
) (
  input  logic [AW-1:0] base_i,
  input  logic [AW-1:0] idx0_i,
  input  logic [1:0]    shift_i,
  input  logic [IW-1:0] col_i,
  input  logic [IW-1:0] ecols_i,
  output logic [AW-1:0] addr_o,
  output logic          null_o
);
  logic [AW-1:0] idx;
  // one extra bit so col+LANE cannot wrap
  assign null_o = ({1'b0, col_i} + (IW+1)'(LANE)) >= {1'b0, ecols_i};
  assign idx    = idx0_i + AW'(LANE);
  assign addr_o = null_o ? NULL_ADDR : base_i + (idx << shift_i);
endmodule

module agu_tile_stream #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    IDX_WIDTH  = 16,
  parameter int                    LANES      = 4,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] NULL_ADDR  = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [IDX_WIDTH-1:0]  mat_m_i, mat_k_i, mat_n_i,
  input  logic [IDX_WIDTH-1:0]  tm_i, tn_i, tk_i,
  input  logic [ADDR_WIDTH-1:0] base_a_i, base_b_i, base_c_i,
  input  logic [1:0]            elem_shift_i,
  input  logic                  tile_req_i,
  output logic                  tile_done_o,
  output logic                  all_tiles_done_o,
  output logic                  busy_o,
  agu_tile_stream_if.master     out_if
);
  localparam int AW = ADDR_WIDTH;
  localparam int IW = IDX_WIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_GEN_A, S_GEN_B, S_GEN_C, S_TEND, S_DONE} state_e;

  typedef struct packed {
    logic [LANES-1:0][AW-1:0] addr;
    logic [LANES-1:0]         nul;
    logic [1:0]               id;
    logic                     last;
  } beat_t;

  state_e state_q, state_d;

  logic [IW-1:0] m_q, k_q, n_q, tm_q, tn_q, tk_q;
  logic [AW-1:0] ba_q, bb_q, bc_q;
  logic [1:0]    sh_q;
  // tile origins in elements, and row/col cursor inside the current operand
  logic [IW-1:0] mo_q, no_q, ko_q, r_q, c_q;

  logic          cfg_acc, zero_cfg, gen, push, pop, last_pop;
  logic          col_end, row_end, seg_end, last_k, last_n, last_m, beat_last;
  logic [IW-1:0] rem_m, rem_n, rem_k, etm, etn, etk;
  logic [IW-1:0] rows, ecols, row_base, col_base, stride;
  logic [AW-1:0] base, idx0;
  logic [1:0]    id;
  logic [LANES-1:0][AW-1:0] lane_addr;
  logic [LANES-1:0]         lane_null;

  assign cfg_acc  = cfg_valid_i & cfg_ready_o;
  assign zero_cfg = (mat_m_i == '0) | (mat_k_i == '0) | (mat_n_i == '0) |
                    (tm_i == '0) | (tn_i == '0) | (tk_i == '0);

  // remaining extent from the tile origin; a tile is the last along an axis
  // when the remainder fits in one tile (avoids origin+T overflow)
  assign rem_m  = m_q - mo_q;
  assign rem_n  = n_q - no_q;
  assign rem_k  = k_q - ko_q;
  assign etm    = (rem_m < tm_q) ? rem_m : tm_q;
  assign etn    = (rem_n < tn_q) ? rem_n : tn_q;
  assign etk    = (rem_k < tk_q) ? rem_k : tk_q;
  assign last_m = rem_m <= tm_q;
  assign last_n = rem_n <= tn_q;
  assign last_k = rem_k <= tk_q;

  // operand select
  always_comb begin
    rows = etm; ecols = etk; row_base = mo_q; col_base = ko_q; stride = k_q; base = ba_q; id = 2'b00;
    unique case (state_q)
      S_GEN_B: begin rows = etk; ecols = etn; row_base = ko_q; col_base = no_q;
                     stride = n_q; base = bb_q; id = 2'b01; end
      S_GEN_C: begin rows = etm; ecols = etn; row_base = mo_q; col_base = no_q;
                     stride = n_q; base = bc_q; id = 2'b10; end
      default: ;
    endcase
  end

  assign idx0 = (AW'(row_base) + AW'(r_q)) * AW'(stride) + AW'(col_base) + AW'(c_q);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    agu_tile_lane #(.AW(AW), .IW(IW), .LANE(l), .NULL_ADDR(NULL_ADDR)) u_lane (
      .base_i(base), .idx0_i(idx0), .shift_i(sh_q), .col_i(c_q), .ecols_i(ecols),
      .addr_o(lane_addr[l]), .null_o(lane_null[l]));
  end

  // ---------------- output FIFO ----------------
  beat_t         fifo_q [FIFO_DEPTH];
  beat_t         head, beat_in;
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;

  assign gen       = (state_q == S_GEN_A) | (state_q == S_GEN_B) | (state_q == S_GEN_C);
  // full stalls the push even if the head pops this cycle
  assign push      = gen & (cnt_q < CW'(FIFO_DEPTH));
  assign col_end   = ({1'b0, c_q} + (IW+1)'(LANES)) >= {1'b0, ecols};
  assign row_end   = r_q == (rows - IW'(1));
  assign seg_end   = col_end & row_end;
  assign beat_last = seg_end & (((state_q == S_GEN_B) & ~last_k) | (state_q == S_GEN_C));
  assign beat_in   = '{addr: lane_addr, nul: lane_null, id: id, last: beat_last};

  assign out_if.out_valid = (cnt_q != '0);
  assign head             = out_if.out_valid ? fifo_q[rp_q] : '0;
  assign out_if.out_addr  = head.addr;
  assign out_if.out_null  = head.nul;
  assign out_if.out_id    = head.id;
  assign out_if.out_last  = head.last;
  assign pop              = out_if.out_valid & out_if.out_ready;
  assign last_pop         = pop & head.last;

  always_ff @(posedge clk) if (push) fifo_q[wp_q] <= beat_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0; rp_q <= '0; cnt_q <= '0;
    end else begin
      if (push) wp_q <= (wp_q == PW'(FIFO_DEPTH-1)) ? '0 : wp_q + PW'(1);
      if (pop)  rp_q <= (rp_q == PW'(FIFO_DEPTH-1)) ? '0 : rp_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (cfg_acc) state_d = zero_cfg ? S_DONE : S_WAIT;
      S_WAIT:  if (tile_req_i)      state_d = S_GEN_A;
      S_GEN_A: if (push & seg_end)  state_d = S_GEN_B;
      S_GEN_B: if (push & seg_end)  state_d = last_k ? S_GEN_C : S_TEND;
      S_GEN_C: if (push & seg_end)  state_d = S_TEND;
      S_TEND:  if (last_pop)        state_d = (last_m & last_n & last_k) ? S_DONE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_o = 1'b0; busy_o = 1'b0; all_tiles_done_o = 1'b0; tile_done_o = 1'b0;
    unique case (state_q)
      S_IDLE:  cfg_ready_o = 1'b1;
      S_DONE:  begin cfg_ready_o = 1'b1; all_tiles_done_o = 1'b1; end
      S_TEND:  begin busy_o = 1'b1; tile_done_o = last_pop; end
      default: busy_o = 1'b1;
    endcase
  end

  // ---------------- config, tile origins, cursor ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= '0; k_q <= '0; n_q <= '0; tm_q <= '0; tn_q <= '0; tk_q <= '0;
      ba_q <= '0; bb_q <= '0; bc_q <= '0; sh_q <= '0;
      mo_q <= '0; no_q <= '0; ko_q <= '0; r_q <= '0; c_q <= '0;
    end else begin
      if (cfg_acc) begin
        m_q <= mat_m_i; k_q <= mat_k_i; n_q <= mat_n_i;
        tm_q <= tm_i; tn_q <= tn_i; tk_q <= tk_i;
        ba_q <= base_a_i; bb_q <= base_b_i; bc_q <= base_c_i; sh_q <= elem_shift_i;
        mo_q <= '0; no_q <= '0; ko_q <= '0; r_q <= '0; c_q <= '0;
      end
      if (push) begin
        if (col_end) begin
          c_q <= '0;
          r_q <= row_end ? '0 : r_q + IW'(1);
        end else begin
          c_q <= c_q + IW'(LANES);
        end
      end
      // k innermost, then j, then i
      if ((state_q == S_TEND) && last_pop) begin
        if (!last_k) ko_q <= ko_q + tk_q;
        else begin
          ko_q <= '0;
          if (!last_n) no_q <= no_q + tn_q;
          else begin
            no_q <= '0;
            if (!last_m) mo_q <= mo_q + tm_q;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_agu_tile_stream.sv
module tb_agu_tile_stream;
  localparam int AW = 32, IW = 16, L = 4, D = 4;

  typedef struct packed {
    logic [L*AW-1:0] addr;
    logic [L-1:0]    nul;
    logic [1:0]      id;
    logic            last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cfg_valid, cfg_ready, tile_req, tile_done, all_done, busy;
  logic [IW-1:0] mm, mk, mn, tm, tn, tk;
  logic [AW-1:0] ba, bb, bc;
  logic [1:0]    sh;

  agu_tile_stream_if #(.LANES(L), .ADDR_WIDTH(AW)) sif ();

  agu_tile_stream #(.ADDR_WIDTH(AW), .IDX_WIDTH(IW), .LANES(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .mat_m_i(mm), .mat_k_i(mk), .mat_n_i(mn), .tm_i(tm), .tn_i(tn), .tk_i(tk),
    .base_a_i(ba), .base_b_i(bb), .base_c_i(bc), .elem_shift_i(sh),
    .tile_req_i(tile_req), .tile_done_o(tile_done), .all_tiles_done_o(all_done),
    .busy_o(busy), .out_if(sif));

  int    n_chk = 0, n_bad = 0;
  int    cyc = 0, ntd = 0, last_td_cyc = -1, atd_cyc = -1, acc_cyc = 0;
  bit    mon_en = 0, rnd_ready = 0, prev_stall = 0, prev_ad = 0;
  beat_t prev_b, cur;
  beat_t obs_q[$], exp_q[$];

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // consumer + monitor: drive ready on the falling edge, sample 1ns later
  initial begin
    sif.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      sif.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cur = {sif.out_addr, sif.out_null, sif.out_id, sif.out_last};
      if (mon_en) begin
        if (prev_stall) chk("stall_hold", {sif.out_valid, cur}, {1'b1, prev_b});
        chk("tile_done", tile_done, sif.out_valid & sif.out_ready & sif.out_last);
        if (sif.out_valid && sif.out_ready) obs_q.push_back(cur);
        if (tile_done) begin ntd++; last_td_cyc = cyc; end
        if (all_done && !prev_ad) atd_cyc = cyc;
      end
      prev_stall = mon_en & sif.out_valid & ~sif.out_ready;
      prev_b     = cur;
      prev_ad    = all_done;
    end
  end

  task automatic add_rows(input logic [31:0] base, input logic [1:0] id, input int r0, input int stride,
                          input int c0, input int nr, input int ec, input int shv);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < ec; c += L) begin
        beat_t b;
        logic [31:0] idx;
        b = '0;
        b.id = id;
        for (int l = 0; l < L; l++)
          if (c + l >= ec) begin
            b.nul[l] = 1'b1;
            b.addr[l*AW +: AW] = '1;
          end else begin
            idx = (r0 + r) * stride + c0 + c + l;
            b.addr[l*AW +: AW] = base + (idx << shv);
          end
        exp_q.push_back(b);
      end
  endtask

  // reference walk: plain loop nest over tiles
  task automatic build_exp(input int M, input int K, input int N, input int T, input logic [31:0] bA,
                           input logic [31:0] bB, input logic [31:0] bC, input int shv, output int ntiles);
    beat_t b;
    exp_q.delete();
    ntiles = 0;
    if (M == 0 || K == 0 || N == 0 || T == 0) return;
    for (int i0 = 0; i0 < M; i0 += T)
      for (int j0 = 0; j0 < N; j0 += T)
        for (int k0 = 0; k0 < K; k0 += T) begin
          int em, en, ek;
          em = (M - i0 < T) ? M - i0 : T;
          en = (N - j0 < T) ? N - j0 : T;
          ek = (K - k0 < T) ? K - k0 : T;
          ntiles++;
          add_rows(bA, 2'b00, i0, K, k0, em, ek, shv);
          add_rows(bB, 2'b01, k0, N, j0, ek, en, shv);
          if (k0 + T >= K) add_rows(bC, 2'b10, i0, N, j0, em, en, shv);
          b = exp_q.pop_back();
          b.last = 1'b1;
          exp_q.push_back(b);
        end
  endtask

  task automatic apply_cfg(input int M, input int K, input int N, input int T, input int shv);
    @(negedge clk);
    mm = IW'(M); mk = IW'(K); mn = IW'(N); tm = IW'(T); tn = IW'(T); tk = IW'(T);
    ba = 32'h1000; bb = 32'h2000; bc = 32'h3000; sh = 2'(shv);
    cfg_valid = 1'b1;
    #3 acc_cyc = cyc;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic run_cfg(input int M, input int K, input int N, input int T, input int shv, input bit lat);
    int nt;
    build_exp(M, K, N, T, 32'h1000, 32'h2000, 32'h3000, shv, nt);
    obs_q.delete();
    ntd = 0; atd_cyc = -1; last_td_cyc = -1;
    tile_req = !lat;
    apply_cfg(M, K, N, T, shv);
    if (lat) begin
      @(negedge clk); @(negedge clk);
      tile_req = 1'b1;
      @(posedge clk);
      @(negedge clk); #2 chk("lat_c1_valid", sif.out_valid, 1'b0);
      chk("busy_gen", busy, 1'b1);
      @(negedge clk); #2 chk("lat_c2_valid", sif.out_valid, 1'b1);
    end
    for (int t = 0; t < 600; t++) begin
      @(negedge clk); #2;
      if (all_done) break;
    end
    chk("done_seen", all_done, 1'b1);
    chk("nbeats", obs_q.size(), exp_q.size());
    for (int b = 0; b < exp_q.size() && b < obs_q.size(); b++) begin
      chk($sformatf("addr[%0d]", b), obs_q[b].addr, exp_q[b].addr);
      chk($sformatf("null[%0d]", b), obs_q[b].nul,  exp_q[b].nul);
      chk($sformatf("id[%0d]", b),   obs_q[b].id,   exp_q[b].id);
      chk($sformatf("last[%0d]", b), obs_q[b].last, exp_q[b].last);
    end
    chk("ntiles", ntd, nt);
    if (nt > 0) chk("atd_after_td", atd_cyc, last_td_cyc + 1);
    else        chk("atd_after_cfg", atd_cyc, acc_cyc + 1);
  endtask

  task automatic pulse_rst();
    mon_en = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; tile_req = 1'b0;
    mm = '0; mk = '0; mn = '0; tm = '0; tn = '0; tk = '0; ba = '0; bb = '0; bc = '0; sh = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", sif.out_valid, 1'b0);
    chk("rst_atd", all_done, 1'b0);
    chk("rst_tdone", tile_done, 1'b0);
    chk("rst_addr", sif.out_addr, '0);
    @(negedge clk); rst = 1'b0;
    mon_en = 1'b1;

    // T1 basic single tile with latency probe
    run_cfg(4, 4, 4, 4, 0, 1'b1);
    if (obs_q.size() == 12) begin
      chk("t1_a0", obs_q[0].addr, {32'h1003, 32'h1002, 32'h1001, 32'h1000});
      chk("t1_a3_l0", obs_q[3].addr[31:0], 32'h100C);
      chk("t1_b0_l0", obs_q[4].addr[31:0], 32'h2000);
      chk("t1_c0_l0", obs_q[8].addr[31:0], 32'h3000);
      chk("t1_last", {obs_q[10].last, obs_q[11].last}, 2'b01);
    end

    // T2 ragged edges
    run_cfg(5, 3, 4, 4, 0, 1'b0);
    chk("t2_nbeats_hand", obs_q.size(), 16);
    if (obs_q.size() == 16) begin
      chk("t2_a0_null", obs_q[0].nul, 4'b1000);
      chk("t2_a0", obs_q[0].addr, {32'hFFFF_FFFF, 32'h1002, 32'h1001, 32'h1000});
      chk("t2_i1_a0", obs_q[11].addr, {32'hFFFF_FFFF, 32'h100E, 32'h100D, 32'h100C});
    end

    // T3 random backpressure
    rnd_ready = 1'b1;
    run_cfg(4, 4, 4, 4, 0, 1'b0);
    rnd_ready = 1'b0;

    // T4 element shift
    run_cfg(4, 4, 4, 4, 2, 1'b0);
    if (obs_q.size() == 12) chk("t4_a1_l0", obs_q[1].addr[31:0], 32'h1010);

    // T5 two k-tiles
    run_cfg(4, 8, 4, 4, 0, 1'b0);
    chk("t5_nbeats_hand", obs_q.size(), 20);
    if (obs_q.size() == 20) begin
      chk("t5_tile1_last", {obs_q[7].last, obs_q[7].id}, {1'b1, 2'b01});
      chk("t5_tile2_a0", obs_q[8].addr[31:0], 32'h1004);
      chk("t5_tile2_b0", obs_q[12].addr[31:0], 32'h2010);
      chk("t5_tile2_last", {obs_q[19].last, obs_q[19].id}, {1'b1, 2'b10});
    end

    // T6 reset in GEN_B, restart, then zero-dimension config
    mon_en = 1'b0;
    tile_req = 1'b1;
    apply_cfg(4, 4, 4, 4, 0);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", sif.out_valid, 1'b0);
    chk("t6_rst_ready", cfg_ready, 1'b1);
    chk("t6_rst_busy", busy, 1'b0);
    @(negedge clk); rst = 1'b0;
    mon_en = 1'b1;
    run_cfg(4, 4, 4, 4, 0, 1'b0);
    pulse_rst();
    run_cfg(4, 0, 4, 4, 0, 1'b0);
    chk("t6_zero_nbeats", obs_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
